// File: rtl/core_pkg.sv
// Shared core definitions used by the load/store unit.
//   - RV32I load/store funct3 encodings
//   - mcause codes raised by data-memory accesses
//   - LSU state encoding
//   - access_bytes(): access size in bytes from funct3[1:0]
package core_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [31:0] MCAUSE_ILLEGAL         = 32'd2;
    localparam logic [31:0] MCAUSE_LOAD_MISALIGN   = 32'd4;
    localparam logic [31:0] MCAUSE_LOAD_FAULT      = 32'd5;
    localparam logic [31:0] MCAUSE_STORE_MISALIGN  = 32'd6;
    localparam logic [31:0] MCAUSE_STORE_FAULT     = 32'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // Byte count of an access; funct3[1:0] = 3 is illegal and caught earlier.
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the LSU.
//   funct3    : load/store funct3 of the access
//   byte_off  : address bits [1:0]
//   rword     : aligned 32-bit little-endian memory word
//   load_data : extracted and sign/zero extended load result
//   wdata     : store data (low bytes used for SB/SH)
//   wstrb     : per-byte write enables within the word
//   wlanes    : store data shifted into its byte lanes
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rword,
    output logic [31:0] load_data,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wlanes
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rword >> {byte_off, 3'b000};
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'b0, shifted[7:0]};
            F3_LHU:  load_data = {16'b0, shifted[15:0]};
            default: load_data = rword;
        endcase
    end

    // Lanes above the access width are harmless: the strobe masks them.
    always_comb begin
        wlanes = wdata << {byte_off, 3'b000};
        case (funct3[1:0])
            2'b00:   wstrb = 4'b0001 << byte_off;
            2'b01:   wstrb = 4'b0011 << byte_off;
            default: wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit with a private byte-addressed data memory.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   req_write, req_funct3 : store/load select and RV32I funct3
//   req_addr, req_wdata   : byte address and store data
//   req_rd                : load destination register
//   flush                 : kill the in-flight request
//   resp_valid            : one-cycle completion pulse
//   resp_rd, resp_rdata   : load destination and extended data (0 otherwise)
//   resp_exc, resp_mcause, resp_mtval : exception report
module lsu
    import core_pkg::*;
#(
    parameter int DMEM_SIZE = 4096,
    parameter int LATENCY   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [31:0] resp_mcause,
    output logic [31:0] resp_mtval
);

    localparam int WORDS = DMEM_SIZE / 4;
    localparam int WAW   = $clog2(WORDS);

    lsu_state_t       state;
    logic [3:0]       wait_cnt;
    logic             write_q;
    logic [2:0]       funct3_q;
    logic [WAW+1:0]   addr_q;
    logic [31:0]      wdata_q;
    logic [4:0]       rd_q;
    logic             exc_q;
    logic [31:0]      mcause_q;
    logic [31:0]      mtval_q;

    // Word-organised storage; legal accesses are aligned so never straddle words.
    // Not reset: contents survive rst_n.
    logic [31:0]      mem [WORDS];

    logic             accept;
    logic             is_illegal;
    logic             is_misalign;
    logic             is_fault;
    logic [32:0]      end_addr;
    logic             mem_we;
    logic [31:0]      rword;
    logic [31:0]      load_data;
    logic [3:0]       wstrb;
    logic [31:0]      wlanes;

    always_comb begin
        accept = req_valid && (state == ST_IDLE) && !flush;

        if (req_write)
            is_illegal = (req_funct3 > F3_SW);
        else
            is_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);

        case (req_funct3[1:0])
            2'b01:   is_misalign = req_addr[0];
            2'b10:   is_misalign = |req_addr[1:0];
            default: is_misalign = 1'b0;
        endcase

        // 33-bit sum so addresses near 2^32 cannot wrap back into range.
        end_addr = {1'b0, req_addr} + 33'(access_bytes(req_funct3[1:0]));
        is_fault = end_addr > 33'(DMEM_SIZE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            exc_q    <= 1'b0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[WAW+1:0];
                        wdata_q  <= req_wdata;
                        exc_q    <= is_illegal || is_misalign || is_fault;
                        rd_q     <= (req_write || is_illegal || is_misalign || is_fault) ? 5'd0 : req_rd;
                        if (is_illegal) begin
                            mcause_q <= MCAUSE_ILLEGAL;
                            mtval_q  <= '0;
                        end else if (is_misalign) begin
                            mcause_q <= req_write ? MCAUSE_STORE_MISALIGN : MCAUSE_LOAD_MISALIGN;
                            mtval_q  <= req_addr;
                        end else if (is_fault) begin
                            mcause_q <= req_write ? MCAUSE_STORE_FAULT : MCAUSE_LOAD_FAULT;
                            mtval_q  <= req_addr;
                        end else begin
                            mcause_q <= '0;
                            mtval_q  <= '0;
                        end
                        // Exceptions skip the wait states entirely.
                        if (is_illegal || is_misalign || is_fault || LATENCY == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            // Counts the WAIT cycles still to go after the first one.
                            wait_cnt <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush)
                        state <= ST_IDLE;
                    else if (wait_cnt == 4'd0)
                        state <= ST_RESP;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Store commits on the edge leaving RESP, unless flushed or faulted.
    // An asynchronous reset forces state to IDLE, so a pending store drops.
    assign mem_we = (state == ST_RESP) && write_q && !exc_q && !flush;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[addr_q[WAW+1:2]][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    assign rword = mem[addr_q[WAW+1:2]];

    lsu_align u_align (
        .funct3    (funct3_q),
        .byte_off  (addr_q[1:0]),
        .rword     (rword),
        .load_data (load_data),
        .wdata     (wdata_q),
        .wstrb     (wstrb),
        .wlanes    (wlanes)
    );

    // A flush during RESP masks the response in that same cycle.
    assign req_ready   = (state == ST_IDLE);
    assign resp_valid  = (state == ST_RESP) && !flush;
    assign resp_exc    = resp_valid && exc_q;
    assign resp_mcause = resp_exc ? mcause_q : 32'd0;
    assign resp_mtval  = resp_exc ? mtval_q : 32'd0;
    assign resp_rd     = resp_valid ? rd_q : 5'd0;
    assign resp_rdata  = (resp_valid && !write_q && !exc_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: two instances (LATENCY 0 and 3) checked
// against a byte-array reference model driven by directed and random requests.
module tb_lsu;

    localparam int DMEM = 256;
    localparam int LAT0 = 0;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, req_write, flush, resp_valid, resp_exc;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata, resp_mcause, resp_mtval;
    logic [1:0][4:0]  req_rd, resp_rd;

    lsu #(.DMEM_SIZE(DMEM), .LATENCY(LAT0)) u_lsu0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_rd(req_rd[0]), .flush(flush[0]), .resp_valid(resp_valid[0]),
        .resp_rd(resp_rd[0]), .resp_rdata(resp_rdata[0]), .resp_exc(resp_exc[0]),
        .resp_mcause(resp_mcause[0]), .resp_mtval(resp_mtval[0])
    );

    lsu #(.DMEM_SIZE(DMEM), .LATENCY(LAT3)) u_lsu3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_rd(req_rd[1]), .flush(flush[1]), .resp_valid(resp_valid[1]),
        .resp_rd(resp_rd[1]), .resp_rdata(resp_rdata[1]), .resp_exc(resp_exc[1]),
        .resp_mcause(resp_mcause[1]), .resp_mtval(resp_mtval[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  ref_mem [2][DMEM];
    logic [31:0] last_rdata, last_cause, last_tval;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? LAT0 : LAT3;
    endfunction

    // Expected outcome of one request, from the architectural rules.
    task automatic model(input int d, input bit w, input bit [2:0] f3, input bit [31:0] a,
                         input bit [4:0] rd, output bit exc, output bit [31:0] cause,
                         output bit [31:0] tval, output bit [31:0] rdata, output bit [4:0] rd_o);
        int size;
        bit illegal;
        bit [31:0] v;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
        exc = 1'b1; rdata = '0; rd_o = '0; tval = a; cause = '0;
        if (illegal) begin
            cause = 2; tval = '0;
        end else if ((a % size) != 0) begin
            cause = w ? 6 : 4;
        end else if (longint'(a) + longint'(size) > longint'(DMEM)) begin
            cause = w ? 7 : 5;
        end else begin
            exc = 1'b0; tval = '0;
            if (!w) begin
                v = '0;
                for (int i = 0; i < size; i++) v |= 32'(ref_mem[d][int'(a) + i]) << (8 * i);
                if (f3 == 3'd0 && v[7])  v[31:8]  = '1;
                if (f3 == 3'd1 && v[15]) v[31:16] = '1;
                rdata = v;
                rd_o  = rd;
            end
        end
    endtask

    task automatic commit(input int d, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        int size;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        for (int i = 0; i < size; i++) ref_mem[d][int'(a) + i] = wd[8*i +: 8];
    endtask

    // Present a request at a negedge; it is accepted on the following posedge.
    task automatic issue(input int d, input bit w, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [4:0] rd, input string tag);
        @(negedge clk);
        chk({tag, ".ready_pre"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_write[d] = w; req_funct3[d] = f3;
        req_addr[d] = a; req_wdata[d] = wd; req_rd[d] = rd;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    task automatic xact(input int d, input bit w, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, input bit [4:0] rd, input string tag);
        bit e; bit [31:0] c, t, r; bit [4:0] ro;
        int k; bit got;
        model(d, w, f3, a, rd, e, c, t, r, ro);
        issue(d, w, f3, a, wd, rd, tag);
        k = 0; got = 1'b0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (resp_valid[d]) got = 1'b1;
            else chk({tag, ".ready_busy"}, 32'(req_ready[d]), 32'd0);
        end
        chk({tag, ".latency"}, 32'(k), e ? 32'd1 : 32'(lat(d) + 1));
        chk({tag, ".ready_resp"}, 32'(req_ready[d]), 32'd0);
        chk({tag, ".exc"},    32'(resp_exc[d]), 32'(e));
        chk({tag, ".mcause"}, resp_mcause[d], c);
        chk({tag, ".mtval"},  resp_mtval[d], t);
        chk({tag, ".rdata"},  resp_rdata[d], r);
        chk({tag, ".rd"},     32'(resp_rd[d]), 32'(ro));
        last_rdata = resp_rdata[d];
        last_cause = resp_mcause[d];
        last_tval  = resp_mtval[d];
        if (w && !e) commit(d, f3, a, wd);
    endtask

    task automatic chk_idle_outputs(input int d, input string tag);
        chk({tag, ".ready"},  32'(req_ready[d]), 32'd1);
        chk({tag, ".valid"},  32'(resp_valid[d]), 32'd0);
        chk({tag, ".rdata"},  resp_rdata[d], 32'd0);
        chk({tag, ".exc"},    32'(resp_exc[d]), 32'd0);
        chk({tag, ".rd"},     32'(resp_rd[d]), 32'd0);
        chk({tag, ".mcause"}, resp_mcause[d], 32'd0);
        chk({tag, ".mtval"},  resp_mtval[d], 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w; bit [2:0] f3; bit [31:0] a;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DMEM; i++) ref_mem[d][i] = 8'h00;
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; flush = '0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        #2;
        chk_idle_outputs(0, "reset0");
        chk_idle_outputs(1, "reset3");
        @(negedge clk);
        rst_n = 1'b1;

        // Sub-word loads of a stored word, zero wait states.
        xact(0, 1, 3'd2, 32'h10, 32'h8badf00d, 5'd0, "sw_10");
        xact(0, 0, 3'd0, 32'h13, 32'h0, 5'd7, "lb_13");
        chk("lb_13.const", last_rdata, 32'hffffff8b);
        xact(0, 0, 3'd4, 32'h13, 32'h0, 5'd8, "lbu_13");
        chk("lbu_13.const", last_rdata, 32'h0000008b);

        // Halfword round trip with three wait states.
        xact(1, 1, 3'd1, 32'h22, 32'h00001234, 5'd0, "sh_22");
        xact(1, 0, 3'd1, 32'h22, 32'h0, 5'd3, "lh_22");
        chk("lh_22.const", last_rdata, 32'h00001234);

        // Exceptions and their priority.
        xact(0, 0, 3'd2, 32'h102, 32'h0, 5'd1, "lw_misal");
        chk("lw_misal.cause", last_cause, 32'd4);
        chk("lw_misal.tval", last_tval, 32'h102);
        xact(0, 1, 3'd2, 32'(DMEM - 2), 32'h1, 5'd0, "sw_end_m2");
        chk("sw_end_m2.cause", last_cause, 32'd6);
        xact(0, 1, 3'd2, 32'(DMEM), 32'h1, 5'd0, "sw_end");
        chk("sw_end.cause", last_cause, 32'd7);
        xact(1, 0, 3'd3, 32'h40, 32'h0, 5'd2, "ld_f3_3");
        chk("ld_f3_3.cause", last_cause, 32'd2);
        chk("ld_f3_3.tval", last_tval, 32'd0);
        xact(0, 0, 3'd2, 32'hfffffffc, 32'h0, 5'd4, "lw_wrap");
        chk("lw_wrap.cause", last_cause, 32'd5);

        // Flush in the second WAIT cycle kills the store.
        issue(1, 1, 3'd2, 32'h40, 32'hffffffff, 5'd0, "flush_wait");
        @(negedge clk);
        @(negedge clk);
        flush[1] = 1'b1;
        @(posedge clk);
        #1 flush[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("flush_wait.no_valid", 32'(resp_valid[1]), 32'd0);
            chk("flush_wait.ready", 32'(req_ready[1]), 32'd1);
        end
        xact(1, 0, 3'd2, 32'h40, 32'h0, 5'd5, "lw_40");
        chk("lw_40.const", last_rdata, 32'h0);

        // Flush during RESP masks the pulse and drops the store.
        issue(0, 1, 3'd2, 32'h48, 32'h12345678, 5'd0, "flush_resp");
        flush[0] = 1'b1;
        #1 chk("flush_resp.valid", 32'(resp_valid[0]), 32'd0);
        @(posedge clk);
        #1 flush[0] = 1'b0;
        xact(0, 0, 3'd2, 32'h48, 32'h0, 5'd6, "lw_48");
        chk("lw_48.const", last_rdata, 32'h0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = 3'd2; req_addr[0] = 32'h10;
        flush[0] = 1'b1;
        @(posedge clk);
        #1 begin req_valid[0] = 1'b0; flush[0] = 1'b0; end
        chk("flush_idle.ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        chk("flush_idle.valid", 32'(resp_valid[0]), 32'd0);

        // Reset during a store's WAIT: dropped, memory retained.
        xact(1, 1, 3'd2, 32'h0, 32'h0000ff80, 5'd0, "sw_0");
        issue(1, 1, 3'd2, 32'h0, 32'hdeadbeef, 5'd0, "sw_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_idle_outputs(1, "mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        xact(1, 0, 3'd5, 32'h0, 32'h0, 5'd9, "lhu_0");
        chk("lhu_0.const", last_rdata, 32'h0000ff80);

        // Randomised traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 120; n++) begin
                w  = 1'($urandom_range(0, 1));
                f3 = ($urandom_range(0, 3) != 0)
                     ? (w ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5) : $urandom_range(0, 2)))
                     : 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: a = 32'($urandom_range(0, DMEM - 1));
                    1: a = 32'(DMEM - 4 + $urandom_range(0, 7));
                    2: a = $urandom;
                    default: a = 32'($urandom_range(0, DMEM - 1)) & ~32'd3;
                endcase
                xact(d, w, f3, a, $urandom, 5'($urandom_range(0, 31)), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
